// File: rtl/anc_pkg.sv
// Shared state encoding and default sample width for the ANC frame sequencer.
package anc_pkg;

  localparam int ANC_DATA_W = 11;

  typedef logic [2:0] anc_state_t;

  localparam anc_state_t ST_IDLE      = 3'd0;
  localparam anc_state_t ST_WAIT_TICK = 3'd1;
  localparam anc_state_t ST_ADC       = 3'd2;
  localparam anc_state_t ST_FILT      = 3'd3;
  localparam anc_state_t ST_SAT       = 3'd4;
  localparam anc_state_t ST_DAC       = 3'd5;

  // True while a frame is in flight; a sample tick seen here is a missed tick.
  function automatic logic frame_active(input anc_state_t s);
    return (s != ST_IDLE) && (s != ST_WAIT_TICK);
  endfunction

endpackage

// File: rtl/anc_rate_divider.sv
// Sample-rate divider: registered Tick every CLK_DIV enabled cycles, one cycle after count CLK_DIV-1.
// No backpressure; count and Tick clear whenever Enable is low.
module anc_rate_divider #(
  parameter int CLK_DIV = 2268
) (
  input  logic Clk_100M,
  input  logic Rst_n,
  input  logic Enable,
  output logic Tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (Enable) begin
      tick_d = wrap;
      cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (!Rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign Tick = tick_q;

endmodule

// File: rtl/anc_sample_sequencer.sv
// Per-sample frame controller: ADC capture, filter run, saturation latch, DAC load; all outputs registered.
// Each strobe is issued one cycle after the transition that requests it; no backpressure, timeouts abort the frame.
module anc_sample_sequencer
  import anc_pkg::*;
#(
  parameter int DATA_W       = ANC_DATA_W,
  parameter int CLK_DIV      = 2268,
  parameter int STEP_TIMEOUT = 2000,
  parameter int CNT_W        = 16
) (
  input  logic              Clk_100M,
  input  logic              Rst_n,
  input  logic              Enable,
  output logic              AdcStart,
  input  logic              AdcDone,
  input  logic [DATA_W-1:0] AdcData,
  output logic [DATA_W-1:0] MicIn,
  output logic              FiltStart,
  input  logic              FiltComplete,
  output logic              SatLatch,
  output logic              DacLoad,
  input  logic              OverrunClr,
  output logic              Overrun,
  output logic [CNT_W-1:0]  FrameCount,
  output logic [2:0]        State
);

  localparam int SW = $clog2(STEP_TIMEOUT + 1);

  anc_state_t        state_q, state_d;
  logic [SW-1:0]     step_q, step_d;
  logic              fc_prev_q;
  logic [DATA_W-1:0] mic_q, mic_d;
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic              ovr_q, ovr_d;
  logic              adc_start_q, adc_start_d;
  logic              filt_start_q, filt_start_d;
  logic              sat_latch_q, sat_latch_d;
  logic              dac_load_q, dac_load_d;

  logic tick;
  logic fc_rise;
  logic step_abort;
  logic ovr_set;

  anc_rate_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_divider (
    .Clk_100M (Clk_100M),
    .Rst_n    (Rst_n),
    .Enable   (Enable),
    .Tick     (tick)
  );

  // A level already high when the filter starts leaves fc_prev_q high, so only a fresh rise counts.
  assign fc_rise = FiltComplete & ~fc_prev_q;

  // Completion in the last allowed cycle wins over the abort.
  assign step_abort = (step_q == SW'(STEP_TIMEOUT - 1)) &&
                      (((state_q == ST_ADC)  && !AdcDone) ||
                       ((state_q == ST_FILT) && !fc_rise));

  always_ff @(posedge Clk_100M) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      fc_prev_q    <= 1'b0;
      mic_q        <= '0;
      frame_q      <= '0;
      ovr_q        <= 1'b0;
      adc_start_q  <= 1'b0;
      filt_start_q <= 1'b0;
      sat_latch_q  <= 1'b0;
      dac_load_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      fc_prev_q    <= FiltComplete;
      mic_q        <= mic_d;
      frame_q      <= frame_d;
      ovr_q        <= ovr_d;
      adc_start_q  <= adc_start_d;
      filt_start_q <= filt_start_d;
      sat_latch_q  <= sat_latch_d;
      dac_load_q   <= dac_load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!Enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_WAIT_TICK;
        ST_WAIT_TICK: if (tick) state_d = ST_ADC;
        ST_ADC: begin
          if (AdcDone)         state_d = ST_FILT;
          else if (step_abort) state_d = ST_WAIT_TICK;
        end
        ST_FILT: begin
          if (fc_rise)         state_d = ST_SAT;
          else if (step_abort) state_d = ST_WAIT_TICK;
        end
        ST_SAT:       state_d = ST_DAC;
        ST_DAC:       state_d = ST_WAIT_TICK;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    adc_start_d  = (state_d == ST_ADC)  && (state_q != ST_ADC);
    filt_start_d = (state_d == ST_FILT) && (state_q != ST_FILT);
    sat_latch_d  = (state_d == ST_SAT)  && (state_q != ST_SAT);
    dac_load_d   = (state_d == ST_DAC)  && (state_q != ST_DAC);

    step_d = '0;
    if ((state_d == state_q) && ((state_q == ST_ADC) || (state_q == ST_FILT)))
      step_d = step_q + SW'(1);

    mic_d = mic_q;
    if ((state_q == ST_ADC) && (state_d == ST_FILT))
      mic_d = AdcData;

    frame_d = frame_q;
    if ((state_q == ST_DAC) && (state_d == ST_WAIT_TICK))
      frame_d = frame_q + CNT_W'(1);

    ovr_set = Enable && (step_abort || (tick && frame_active(state_q)));
    ovr_d   = ovr_q;
    if (ovr_set)
      ovr_d = 1'b1;
    else if (OverrunClr)
      ovr_d = 1'b0;
  end

  assign AdcStart   = adc_start_q;
  assign FiltStart  = filt_start_q;
  assign SatLatch   = sat_latch_q;
  assign DacLoad    = dac_load_q;
  assign MicIn      = mic_q;
  assign Overrun    = ovr_q;
  assign FrameCount = frame_q;
  assign State      = state_q;

endmodule

// File: tb/tb_anc_sample_sequencer.sv
// Bench for anc_sample_sequencer with CLK_DIV=16, STEP_TIMEOUT=8: per-cycle model compare plus directed scenarios.
module tb_anc_sample_sequencer;

  localparam int DIV = 16;
  localparam int TO  = 8;
  localparam int DW  = 11;
  localparam int CW  = 16;

  localparam int S_IDLE = 0, S_WAIT = 1, S_ADC = 2, S_FILT = 3, S_SAT = 4, S_DAC = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, en = 1'b0, adc_done = 1'b0, fc = 1'b0, clr = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_start, filt_start, sat_latch, dac_load, overrun;
  logic [DW-1:0] mic;
  logic [CW-1:0] frames;
  logic [2:0]    state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  anc_sample_sequencer #(
    .DATA_W       (DW),
    .CLK_DIV      (DIV),
    .STEP_TIMEOUT (TO),
    .CNT_W        (CW)
  ) dut (
    .Clk_100M     (clk),
    .Rst_n        (rst_n),
    .Enable       (en),
    .AdcStart     (adc_start),
    .AdcDone      (adc_done),
    .AdcData      (adc_data),
    .MicIn        (mic),
    .FiltStart    (filt_start),
    .FiltComplete (fc),
    .SatLatch     (sat_latch),
    .DacLoad      (dac_load),
    .OverrunClr   (clr),
    .Overrun      (overrun),
    .FrameCount   (frames),
    .State        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: ticks follow from how long Enable has been held; frame steps from spec rules.
  int            m_state = S_IDLE, m_enrun = 0, m_dwell = 0, m_frames = 0;
  bit            m_fcprev = 1'b0, m_ovr = 1'b0;
  bit            m_adcst = 1'b0, m_filtst = 1'b0, m_sat = 1'b0, m_dac = 1'b0;
  logic [DW-1:0] m_mic = '0;

  always @(posedge clk) begin : model
    bit tick, rise, ovr_set;
    cyc++;
    tick = (m_enrun > 0) && (m_enrun % DIV == 0);
    rise = fc && !m_fcprev;
    {m_adcst, m_filtst, m_sat, m_dac} = 4'b0;
    ovr_set = 1'b0;
    if (!rst_n) begin
      m_state = S_IDLE; m_enrun = 0; m_dwell = 0; m_frames = 0;
      m_ovr = 1'b0; m_mic = '0;
    end else if (!en) begin
      m_state = S_IDLE;
      m_enrun = 0;
      if (clr) m_ovr = 1'b0;
    end else begin
      m_enrun++;
      if (tick && m_state != S_IDLE && m_state != S_WAIT) ovr_set = 1'b1;
      case (m_state)
        S_IDLE: m_state = S_WAIT;
        S_WAIT: if (tick) begin m_state = S_ADC; m_adcst = 1'b1; m_dwell = 1; end
        S_ADC: begin
          if (adc_done) begin m_mic = adc_data; m_state = S_FILT; m_filtst = 1'b1; m_dwell = 1; end
          else if (m_dwell == TO) begin ovr_set = 1'b1; m_state = S_WAIT; end
          else m_dwell++;
        end
        S_FILT: begin
          if (rise) begin m_state = S_SAT; m_sat = 1'b1; end
          else if (m_dwell == TO) begin ovr_set = 1'b1; m_state = S_WAIT; end
          else m_dwell++;
        end
        S_SAT: begin m_state = S_DAC; m_dac = 1'b1; end
        S_DAC: begin m_state = S_WAIT; m_frames = (m_frames + 1) % (1 << CW); end
        default: ;
      endcase
      m_ovr = ovr_set ? 1'b1 : (clr ? 1'b0 : m_ovr);
    end
    m_fcprev = rst_n && fc;
    #1;
    chk("state", state, m_state);
    chk("adc_start", adc_start, m_adcst);
    chk("filt_start", filt_start, m_filtst);
    chk("sat_latch", sat_latch, m_sat);
    chk("dac_load", dac_load, m_dac);
    chk("mic_in", mic, m_mic);
    chk("overrun", overrun, m_ovr);
    chk("frame_count", frames, m_frames);
  end

  function automatic logic sig(input int which);
    case (which)
      0:       return adc_start;
      1:       return filt_start;
      2:       return sat_latch;
      3:       return dac_load;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, input string nm, output int n);
    n = 0;
    while (!sig(which)) begin
      if (n >= budget) begin
        checks++;
        failures++;
        $display("FAIL wait_%s: strobe absent after %0d cycles, required within %0d", nm, n, budget);
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic adc_reply(input int k, input logic [DW-1:0] d);
    repeat (k - 1) @(negedge clk);
    adc_done = 1'b1;
    adc_data = d;
    @(negedge clk);
    adc_done = 1'b0;
  endtask

  initial begin
    int n, t0, fcyc;
    bit seen;

    // Normal frame
    do_reset();
    en = 1'b1;
    wait_sig(0, 40, "adc1", n);
    adc_reply(3, 11'h155);
    wait_sig(1, 2, "filt1", n);
    repeat (4) @(negedge clk);
    fc = 1'b1;
    wait_sig(2, 6, "sat1", n);
    chk("s1_mic_at_sat", mic, 11'h155);
    @(negedge clk);
    chk("s1_dac_after_sat", dac_load, 1);
    chk("s1_sat_single", sat_latch, 0);
    @(negedge clk);
    chk("s1_frames", frames, 1);
    chk("s1_overrun", overrun, 0);
    chk("s1_state", state, S_WAIT);
    fc = 1'b0; en = 1'b0;
    @(negedge clk);

    // FiltComplete stuck high: no edge, filter step times out
    fc = 1'b1;
    do_reset();
    en = 1'b1;
    wait_sig(0, 40, "adc2", n);
    adc_reply(3, 11'h0F0);
    fcyc = 0; seen = 1'b0;
    while (state == S_FILT && fcyc < 20) begin
      fcyc++;
      seen |= sat_latch;
      @(negedge clk);
    end
    chk("s2_filt_cycles", fcyc, 8);
    chk("s2_state", state, S_WAIT);
    chk("s2_overrun", overrun, 1);
    repeat (3) begin
      seen |= sat_latch | dac_load;
      @(negedge clk);
    end
    chk("s2_no_sat_dac", seen, 0);
    fc = 1'b0; en = 1'b0;
    @(negedge clk);

    // Slow frame: tick lands in DAC, frame still completes, next tick served
    do_reset();
    en = 1'b1;
    wait_sig(0, 40, "adc3", n);
    t0 = cyc;
    adc_reply(7, 11'h3C3);
    repeat (6) @(negedge clk);
    fc = 1'b1;
    wait_sig(3, 6, "dac3", n);
    chk("s3_overrun_before_tick", overrun, 0);
    @(negedge clk);
    chk("s3_overrun_missed_tick", overrun, 1);
    chk("s3_frames", frames, 1);
    fc = 1'b0;
    wait_sig(0, 30, "adc3b", n);
    chk("s3_next_adcstart_gap", cyc - t0, 32);
    en = 1'b0;
    @(negedge clk);

    // Enable dropped mid-filter, late FiltComplete ignored, restart latency
    en = 1'b1;
    wait_sig(0, 40, "adc4", n);
    adc_reply(3, 11'h0AA);
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("s4_idle", state, S_IDLE);
    chk("s4_mic_hold", mic, 11'h0AA);
    chk("s4_ovr_hold", overrun, 1);
    chk("s4_frames_hold", frames, 1);
    fc = 1'b1;
    @(negedge clk);
    fc = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    wait_sig(0, 40, "adc4b", n);
    chk("s4_restart_latency", n, 17);

    // Reset asserted while in SAT
    adc_reply(3, 11'h2AA);
    @(negedge clk);
    fc = 1'b1;
    wait_sig(2, 4, "sat5", n);
    chk("s5_mic_before", mic, 11'h2AA);
    chk("s5_frames_before", frames, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("s5_sat", sat_latch, 0);
    chk("s5_dac", dac_load, 0);
    chk("s5_frames", frames, 0);
    chk("s5_mic", mic, 0);
    chk("s5_state", state, S_IDLE);
    rst_n = 1'b1; fc = 1'b0; en = 1'b0;
    @(negedge clk);

    // OverrunClr coinciding with a timeout loses; clear alone wins
    do_reset();
    en = 1'b1;
    wait_sig(0, 40, "adc6", n);
    adc_reply(3, 11'h111);
    repeat (7) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("s6_set_beats_clr", overrun, 1);
    chk("s6_state", state, S_WAIT);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("s6_clr", overrun, 0);
    en = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
